// File: rtl/sudoku_sweep_ctrl.sv
// Sweep sequencer for the sudoku constraint datapath: walks the 81 cells in
// raster order and issues ROW/COL/BOX/FINAL checks per cell over req/ack,
// repeating sweeps until the board is solved, stuck or contradictory.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a solve (accepted only when idle)
//   load               1-cycle pulse: datapath latches the entered board
//   chk_req            op request, held until chk_ack
//   chk_op             0=ROW 1=COL 2=BOX 3=FINAL
//   cell_row/cell_col  cell under check, 0..8
//   chk_ack            datapath completed the op
//   chk_changed        op removed a candidate or set a final (with ack)
//   chk_final          cell is final (with ack, FINAL op)
//   chk_empty          cell mask empty, contradiction (with ack)
//   busy               solve in progress
//   done               1-cycle completion pulse
//   status             0=NONE 1=SOLVED 2=STUCK 3=CONTRA 4=TIMEOUT
//   sweep_cnt          completed sweeps in the current solve
//
// Optional feature: define SWEEP_LIMIT_EN to stop with TIMEOUT after
// MAX_SWEEPS sweeps that still made progress.
module sudoku_sweep_ctrl #(
    parameter int MAX_SWEEPS = 64,
    parameter int SWEEP_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               load,
    output logic               chk_req,
    output logic [1:0]         chk_op,
    output logic [3:0]         cell_row,
    output logic [3:0]         cell_col,
    input  logic               chk_ack,
    input  logic               chk_changed,
    input  logic               chk_final,
    input  logic               chk_empty,
    output logic               busy,
    output logic               done,
    output logic [2:0]         status,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_EVAL, S_DONE
    } state_t;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_SOLVED  = 3'd1;
    localparam logic [2:0] ST_STUCK   = 3'd2;
    localparam logic [2:0] ST_CONTRA  = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    if (MAX_SWEEPS < 1 || MAX_SWEEPS >= (2 ** SWEEP_W)) begin : g_cap_chk
        $error("MAX_SWEEPS must fit in sweep_cnt");
    end

    state_t             state, state_nx;
    logic [1:0]         op_nx;
    logic [3:0]         row_nx, col_nx;
    logic               dirty, dirty_nx;
    logic [6:0]         fcnt, fcnt_nx;
    logic [2:0]         status_nx;
    logic [SWEEP_W-1:0] sweep_nx, sweep_inc;
    logic               limit_hit;

    assign sweep_inc = (&sweep_cnt) ? sweep_cnt : sweep_cnt + SWEEP_W'(1);

`ifdef SWEEP_LIMIT_EN
    assign limit_hit = (sweep_inc == SWEEP_W'(MAX_SWEEPS));
`else
    assign limit_hit = 1'b0;
`endif

    // Request is a pure decode of the state register, so an asynchronous
    // reset drops it in the same instant.
    assign load    = (state == S_LOAD);
    assign chk_req = (state == S_WAIT);
    assign done    = (state == S_DONE);
    assign busy    = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            chk_op    <= '0;
            cell_row  <= '0;
            cell_col  <= '0;
            dirty     <= 1'b0;
            fcnt      <= '0;
            status    <= ST_NONE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nx;
            chk_op    <= op_nx;
            cell_row  <= row_nx;
            cell_col  <= col_nx;
            dirty     <= dirty_nx;
            fcnt      <= fcnt_nx;
            status    <= status_nx;
            sweep_cnt <= sweep_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        op_nx     = chk_op;
        row_nx    = cell_row;
        col_nx    = cell_col;
        dirty_nx  = dirty;
        fcnt_nx   = fcnt;
        status_nx = status;
        sweep_nx  = sweep_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_LOAD;
                    status_nx = ST_NONE;
                    sweep_nx  = '0;
                end
            end
            S_LOAD: begin
                dirty_nx = 1'b0;
                fcnt_nx  = '0;
                op_nx    = '0;
                row_nx   = '0;
                col_nx   = '0;
                state_nx = S_ISSUE;
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (chk_ack) begin
                    if (chk_changed)
                        dirty_nx = 1'b1;
                    if (chk_final && chk_op == 2'd3)
                        fcnt_nx = fcnt + 7'd1;
                    if (chk_empty) begin
                        status_nx = ST_CONTRA;
                        state_nx  = S_DONE;
                    end else begin
                        state_nx = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                state_nx = S_ISSUE;
                if (chk_op != 2'd3) begin
                    op_nx = chk_op + 2'd1;
                end else begin
                    op_nx = '0;
                    if (cell_col != 4'd8) begin
                        col_nx = cell_col + 4'd1;
                    end else begin
                        col_nx = '0;
                        if (cell_row != 4'd8) begin
                            row_nx = cell_row + 4'd1;
                        end else begin
                            row_nx   = '0;
                            state_nx = S_EVAL;
                        end
                    end
                end
            end
            S_EVAL: begin
                sweep_nx = sweep_inc;
                if (fcnt == 7'd81) begin
                    status_nx = ST_SOLVED;
                    state_nx  = S_DONE;
                end else if (!dirty) begin
                    status_nx = ST_STUCK;
                    state_nx  = S_DONE;
                end else if (limit_hit) begin
                    status_nx = ST_TIMEOUT;
                    state_nx  = S_DONE;
                end else begin
                    dirty_nx = 1'b0;
                    fcnt_nx  = '0;
                    op_nx    = '0;
                    row_nx   = '0;
                    col_nx   = '0;
                    state_nx = S_ISSUE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sudoku_sweep_ctrl.sv
// Testbench for sudoku_sweep_ctrl: datapath responder model plus a
// scoreboard of expected solve results checked on each done pulse.
module tb_sudoku_sweep_ctrl;

    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic          changed = 1'b0;
    logic          fin = 1'b0;
    logic          empty = 1'b0;
    logic          load, req, busy, done;
    logic [1:0]    op;
    logic [3:0]    row, col;
    logic [2:0]    status;
    logic [SW-1:0] sweep;

    always #5 clk = ~clk;

    sudoku_sweep_ctrl #(.MAX_SWEEPS(3), .SWEEP_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load(load),
        .chk_req(req), .chk_op(op), .cell_row(row), .cell_col(col),
        .chk_ack(ack), .chk_changed(changed), .chk_final(fin),
        .chk_empty(empty), .busy(busy), .done(done),
        .status(status), .sweep_cnt(sweep)
    );

    int total = 0;
    int bad = 0;
    int reqs = 0;
    int e_op, e_row, e_col;
    bit fin_all = 0;
    bit rnd = 0;
    int chg_upto = 0;
    bit emp_en = 0;
    int emp_s, emp_r, emp_c, emp_o;

    typedef struct {
        int st;
        int sw;
        int rq;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Datapath model: acks each request after 0..5 extra cycles and checks
    // op sequencing/stability. Returns on done, or when a new request
    // appears after stop_at requests (leaving it pending).
    task automatic serve(input int maxc, input int stop_at, output bit got);
        int d = 0;
        bit acked = 0;
        bit in_req = 0;
        int s;
        logic [1:0] c_op;
        logic [3:0] c_row, c_col;
        got = 0;
        for (int cyc = 0; cyc < maxc; cyc++) begin
            @(negedge clk);
            ack = 0; changed = 0; fin = 0; empty = 0;
            if (acked) begin
                chk("req_low_after_ack", req, 0);
                acked = 0;
                in_req = 0;
            end
            if (done) begin
                got = 1;
                return;
            end
            if (req && !in_req) begin
                if (reqs == stop_at) return;
                reqs++;
                in_req = 1;
                c_op = op; c_row = row; c_col = col;
                chk("op_order", op, e_op);
                chk("row_order", row, e_row);
                chk("col_order", col, e_col);
                d = rnd ? int'($urandom_range(0, 5)) : 0;
            end else if (in_req) begin
                chk("req_held", req, 1);
                chk("op_stable", op, c_op);
                chk("row_stable", row, c_row);
                chk("col_stable", col, c_col);
            end
            if (in_req && d == 0) begin
                s = (reqs - 1) / 324;
                ack = 1;
                changed = (s < chg_upto);
                fin = fin_all && (c_op == 2'd3);
                empty = emp_en && s == emp_s && c_row == emp_r
                        && c_col == emp_c && c_op == emp_o;
                acked = 1;
                if (e_op < 3) e_op++;
                else begin
                    e_op = 0;
                    if (e_col < 8) e_col++;
                    else begin
                        e_col = 0;
                        e_row = (e_row < 8) ? e_row + 1 : 0;
                    end
                end
            end else if (in_req) begin
                d--;
            end
        end
        total++;
        bad++;
        $error("FAIL serve_budget observed=%0d expected=%0d", reqs, stop_at);
    endtask

    task automatic begin_solve(input bit push, input int st, input int sw,
                               input int rq);
        exp_t e;
        if (push) begin
            e.st = st; e.sw = sw; e.rq = rq;
            sb.push_back(e);
        end
        reqs = 0; e_op = 0; e_row = 0; e_col = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("load_pulse", load, 1);
        chk("busy_up", busy, 1);
        chk("status_clr", status, 0);
        chk("sweep_clr", sweep, 0);
        @(negedge clk);
        chk("load_once", load, 0);
    endtask

    task automatic end_solve(input int maxc);
        bit got;
        exp_t e;
        serve(maxc, -1, got);
        chk("done_seen", got, 1);
        e = sb.pop_front();
        chk("status", status, e.st);
        chk("sweeps", sweep, e.sw);
        chk("reqs", reqs, e.rq);
        chk("busy_in_done", busy, 0);
        @(negedge clk);
        chk("done_1cyc", done, 0);
        chk("busy_low", busy, 0);
        chk("status_hold", status, e.st);
        chk("sweep_hold", sweep, e.sw);
    endtask

    initial begin
        bit got;
        #3;
        chk("rst_req", req, 0);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op", op, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_status", status, 0);
        chk("rst_sweep", sweep, 0);
        @(negedge clk);
        rst_n = 1;

        // 1: all finals, no change -> solved in one sweep
        fin_all = 1; chg_upto = 0;
        begin_solve(1, 1, 1, 324);
        end_solve(5000);

        // 2: progress in sweep 1 only, never solved -> stuck
        fin_all = 0; chg_upto = 1;
        begin_solve(1, 2, 2, 648);
        end_solve(10000);

        // 3: empty mask at (4,7) BOX -> contradiction
        emp_en = 1; emp_s = 0; emp_r = 4; emp_c = 7; emp_o = 2;
        begin_solve(1, 3, 0, 175);
        end_solve(5000);
        emp_en = 0;

        // 4: random ack latency
        rnd = 1; fin_all = 1; chg_upto = 0;
        begin_solve(1, 1, 1, 324);
        end_solve(8000);
        rnd = 0;

        // 5: progress every sweep
        fin_all = 0; chg_upto = 1000;
`ifdef SWEEP_LIMIT_EN
        begin_solve(1, 4, 3, 972);
        end_solve(15000);
`else
        begin_solve(0, 0, 0, 0);
        serve(15000, 972, got);
        chk("nocap_no_done", got, 0);
        chk("nocap_busy", busy, 1);
        chk("nocap_sweeps", sweep, 3);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
`endif

        // 6: start while busy ignored, then reset mid-wait in sweep 2
        begin_solve(0, 0, 0, 0);
        serve(5000, 329, got);
        chk("mid_sweep", sweep, 1);
        chk("mid_req", req, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_start_noload", load, 0);
        chk("busy_start_busy", busy, 1);
        chk("busy_start_req", req, 1);
        chk("busy_start_sweep", sweep, 1);
        rst_n = 0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sweep", sweep, 0);
        chk("arst_status", status, 0);
        @(negedge clk);
        rst_n = 1;
        begin_solve(0, 0, 0, 0);
        serve(50, 0, got);
        chk("fresh_req", req, 1);
        chk("fresh_op", op, 0);
        chk("fresh_row", row, 0);
        chk("fresh_col", col, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
